// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit driving a word-wide memory port
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

module load_store_unit #(
  parameter int SIZE = `MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o
);

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_DATA, RESP} state_t;
  state_t state_q, state_d;

  logic        we_q, we_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] maddr_q, maddr_d;
  logic        rstrb_q, rstrb_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] mwdata_q, mwdata_d;

  logic [31:0] eff_addr;
  logic        align_err;
  logic        req_err;
  logic        accept;
  logic [3:0]  wmask_req;
  logic [31:0] shifted;
  logic [31:0] extended;

`ifdef LSU_MISALIGN_TRAP_EN
  assign eff_addr  = req_addr_i;
  assign align_err = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                     ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  // Unaligned low bits are simply dropped so the access stays within one word.
  assign eff_addr  = {req_addr_i[31:2],
                      req_addr_i[1] & (req_size_i != 2'b10),
                      req_addr_i[0] & (req_size_i == 2'b00)};
  assign align_err = 1'b0;
`endif

  assign req_err     = (req_size_i == 2'b11) || (req_addr_i >= SIZE_W) || align_err;
  assign req_ready_o = (state_q == IDLE) && rst;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    wmask_req = 4'b1111;
    case (req_size_i)
      2'b00:   wmask_req = 4'b0001 << eff_addr[1:0];
      2'b01:   wmask_req = 4'b0011 << eff_addr[1:0];
      default: wmask_req = 4'b1111;
    endcase
  end

  assign shifted = mem_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    extended = shifted;
    case (size_q)
      2'b00:   extended = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   extended = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    lane_d   = lane_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    // Strobe and mask default low so they only survive the single ISSUE cycle.
    rstrb_d  = 1'b0;
    wmask_d  = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          lane_d  = eff_addr[1:0];
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          rdata_d = 32'd0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            state_d  = ISSUE;
            maddr_d  = {eff_addr[31:2], 2'b00};
            rstrb_d  = ~req_we_i;
            wmask_d  = req_we_i ? wmask_req : 4'b0000;
            mwdata_d = req_wdata_i << {eff_addr[1:0], 3'b000};
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : RD_DATA;
      end
      RD_DATA: begin
        rdata_d = extended;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      maddr_q  <= 32'd0;
      rstrb_q  <= 1'b0;
      wmask_q  <= 4'b0000;
      mwdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      rstrb_q  <= rstrb_d;
      wmask_q  <= wmask_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_addr_o  = maddr_q;
  assign mem_rstrb_o = rstrb_q;
  assign mem_wmask_o = wmask_q;
  assign mem_wdata_o = mwdata_q;

endmodule
